// File: rtl/wb_dest_pipe_pkg.sv
// Shared constants for the destination/write-back pipeline: forwarding select
// encodings, the hard-wired zero register and default widths.
package wb_dest_pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    localparam int unsigned REG_ZERO = 0;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/wb_dest_pipe_fwd_select.sv
// Per-operand forwarding select; the newest producer (EX/MEM) wins over MEM/WB,
// and a load still in EX/MEM cannot forward because its data does not exist yet.
module wb_dest_pipe_fwd_select
    import wb_dest_pipe_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_we,
    input  logic              mem_load,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              wb_we,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_NONE;
        if (op_addr != ADDR_W'(REG_ZERO)) begin
            if (mem_we && !mem_load && (mem_addr == op_addr)) begin
                sel = FWD_EXMEM;
            end else if (wb_we && (wb_addr == op_addr)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/wb_dest_pipe.sv
// Carries destination address, write enable and result from EX through EX/MEM and
// MEM/WB to the register-file write port; also drives forwarding and load-use detect.
module wb_dest_pipe
    import wb_dest_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ex_write_addr,
    input  logic              ex_reg_write,
    input  logic              ex_mem_to_reg,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_bubble,
    input  logic [ADDR_W-1:0] ex_rs,
    input  logic [ADDR_W-1:0] ex_rt,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic              mem_reg_write,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [ADDR_W-1:0] wb_write_addr,
    output logic              wb_reg_write,
    output logic [DATA_W-1:0] wb_write_data,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              load_use_hazard
);

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic              mem_load_q;
    logic [DATA_W-1:0] mem_alu_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic              wb_we_q;
    logic [DATA_W-1:0] wb_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_load_q <= 1'b0;
            mem_alu_q  <= '0;
            wb_addr_q  <= '0;
            wb_we_q    <= 1'b0;
            wb_data_q  <= '0;
        end else begin
            if (ex_bubble) begin
                mem_addr_q <= '0;
                mem_we_q   <= 1'b0;
                mem_load_q <= 1'b0;
                mem_alu_q  <= '0;
            end else begin
                mem_addr_q <= ex_write_addr;
                // $zero is never a real destination, so it never writes or forwards
                mem_we_q   <= ex_reg_write && (ex_write_addr != ADDR_W'(REG_ZERO));
                mem_load_q <= ex_mem_to_reg;
                mem_alu_q  <= ex_alu_result;
            end
            wb_addr_q <= mem_addr_q;
            wb_we_q   <= mem_we_q;
            wb_data_q <= mem_load_q ? mem_read_data : mem_alu_q;
        end
    end

    assign mem_write_addr = mem_addr_q;
    assign mem_reg_write  = mem_we_q;
    assign mem_alu_result = mem_alu_q;
    assign wb_write_addr  = wb_addr_q;
    assign wb_reg_write   = wb_we_q;
    assign wb_write_data  = wb_data_q;

    wb_dest_pipe_fwd_select #(
        .ADDR_W (ADDR_W)
    ) u_fwd_a (
        .op_addr  (ex_rs),
        .mem_addr (mem_addr_q),
        .mem_we   (mem_we_q),
        .mem_load (mem_load_q),
        .wb_addr  (wb_addr_q),
        .wb_we    (wb_we_q),
        .sel      (forward_a)
    );

    wb_dest_pipe_fwd_select #(
        .ADDR_W (ADDR_W)
    ) u_fwd_b (
        .op_addr  (ex_rt),
        .mem_addr (mem_addr_q),
        .mem_we   (mem_we_q),
        .mem_load (mem_load_q),
        .wb_addr  (wb_addr_q),
        .wb_we    (wb_we_q),
        .sel      (forward_b)
    );

    always_comb begin
        load_use_hazard = 1'b0;
        if (mem_we_q && mem_load_q && (mem_addr_q != ADDR_W'(REG_ZERO))) begin
            load_use_hazard = (mem_addr_q == ex_rs) || (mem_addr_q == ex_rt);
        end
    end

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Directed cycle-by-cycle vectors for wb_dest_pipe plus hand-written sequences for
// same-register back-to-back writes and a reset that discards in-flight writes.
module tb_wb_dest_pipe;

    logic        clk;
    logic        reset;
    logic [4:0]  ex_write_addr;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic [31:0] ex_alu_result;
    logic        ex_bubble;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [31:0] mem_read_data;
    logic [4:0]  mem_write_addr;
    logic        mem_reg_write;
    logic [31:0] mem_alu_result;
    logic [4:0]  wb_write_addr;
    logic        wb_reg_write;
    logic [31:0] wb_write_data;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic        load_use_hazard;

    int checks;
    int failures;

    wb_dest_pipe dut (
        .clk             (clk),
        .reset           (reset),
        .ex_write_addr   (ex_write_addr),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_to_reg   (ex_mem_to_reg),
        .ex_alu_result   (ex_alu_result),
        .ex_bubble       (ex_bubble),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .mem_read_data   (mem_read_data),
        .mem_write_addr  (mem_write_addr),
        .mem_reg_write   (mem_reg_write),
        .mem_alu_result  (mem_alu_result),
        .wb_write_addr   (wb_write_addr),
        .wb_reg_write    (wb_reg_write),
        .wb_write_data   (wb_write_data),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .load_use_hazard (load_use_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied during one cycle, and the outputs expected during that same
    // cycle (before the edge that consumes the inputs).
    typedef struct {
        logic        rst;
        logic        bub;
        logic        rw;
        logic        m2r;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rd;
        logic [4:0]  mwa;
        logic        mrw;
        logic [31:0] malu;
        logic [4:0]  wwa;
        logic        wrw;
        logic [31:0] wwd;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        haz;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic bub, input logic rw, input logic m2r,
                         input logic [4:0] wa, input logic [31:0] alu, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [31:0] rd);
        reset         = rst;
        ex_bubble     = bub;
        ex_reg_write  = rw;
        ex_mem_to_reg = m2r;
        ex_write_addr = wa;
        ex_alu_result = alu;
        ex_rs         = rs;
        ex_rt         = rt;
        mem_read_data = rd;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //          rst bub rw m2r wa     alu         rs     rt     rd
        //          mwa    mrw malu        wwa    wrw wwd          fa     fb     haz
        vecs[0]  = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[1]  = '{0, 0, 1, 1, 5'd8, 32'h55, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[2]  = '{1, 0, 0, 0, 5'd0, 32'h0, 5'd8, 5'd0, 32'h0,
                     5'd8, 1, 32'h55, 5'd0, 0, 32'h0, 2'b00, 2'b00, 1};
        vecs[3]  = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd8, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[4]  = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[5]  = '{0, 0, 1, 0, 5'd9, 32'h1234, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[6]  = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0,
                     5'd9, 1, 32'h1234, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[7]  = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd9, 1, 32'h1234, 2'b00, 2'b00, 0};
        vecs[8]  = '{0, 0, 1, 0, 5'd0, 32'h77, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[9]  = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h77, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[10] = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h77, 2'b00, 2'b00, 0};
        vecs[11] = '{0, 0, 1, 0, 5'd5, 32'hAA, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[12] = '{0, 0, 1, 0, 5'd5, 32'hBB, 5'd0, 5'd0, 32'h0,
                     5'd5, 1, 32'hAA, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[13] = '{0, 1, 1, 0, 5'd5, 32'hCC, 5'd5, 5'd5, 32'h0,
                     5'd5, 1, 32'hBB, 5'd5, 1, 32'hAA, 2'b10, 2'b10, 0};
        vecs[14] = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd5, 5'd5, 32'h0,
                     5'd0, 0, 32'h0, 5'd5, 1, 32'hBB, 2'b01, 2'b01, 0};
        vecs[15] = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd5, 5'd5, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[16] = '{0, 0, 1, 1, 5'd7, 32'h100, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[17] = '{0, 1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd7, 32'hDEAD,
                     5'd7, 1, 32'h100, 5'd0, 0, 32'h0, 2'b00, 2'b00, 1};
        vecs[18] = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd7, 32'h0,
                     5'd0, 0, 32'h0, 5'd7, 1, 32'hDEAD, 2'b00, 2'b01, 0};
        vecs[19] = '{0, 0, 1, 0, 5'd4, 32'h44, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};
        vecs[20] = '{0, 1, 1, 0, 5'd3, 32'h33, 5'd4, 5'd0, 32'h0,
                     5'd4, 1, 32'h44, 5'd0, 0, 32'h0, 2'b10, 2'b00, 0};
        vecs[21] = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd4, 32'h0,
                     5'd0, 0, 32'h0, 5'd4, 1, 32'h44, 2'b00, 2'b01, 0};
        vecs[22] = '{0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0,
                     5'd0, 0, 32'h0, 5'd0, 0, 32'h0, 2'b00, 2'b00, 0};

        drive(1, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].bub, vecs[i].rw, vecs[i].m2r, vecs[i].wa,
                  vecs[i].alu, vecs[i].rs, vecs[i].rt, vecs[i].rd);
            #2;
            chk("mem_write_addr", i, 32'(mem_write_addr), 32'(vecs[i].mwa));
            chk("mem_reg_write", i, 32'(mem_reg_write), 32'(vecs[i].mrw));
            chk("mem_alu_result", i, mem_alu_result, vecs[i].malu);
            chk("wb_write_addr", i, 32'(wb_write_addr), 32'(vecs[i].wwa));
            chk("wb_reg_write", i, 32'(wb_reg_write), 32'(vecs[i].wrw));
            chk("wb_write_data", i, wb_write_data, vecs[i].wwd);
            chk("forward_a", i, 32'(forward_a), 32'(vecs[i].fa));
            chk("forward_b", i, 32'(forward_b), 32'(vecs[i].fb));
            chk("load_use_hazard", i, 32'(load_use_hazard), 32'(vecs[i].haz));
        end

        // Back-to-back writes to r6 must both reach WB, in order, unmerged.
        @(negedge clk);
        drive(0, 0, 1, 0, 5'd6, 32'h11, 5'd0, 5'd0, 32'h0);
        @(negedge clk);
        drive(0, 0, 1, 0, 5'd6, 32'h22, 5'd0, 5'd0, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 5'd0, 32'h0, 5'd6, 5'd0, 32'h0);
        #2;
        chk("b2b_wb_first", 100, wb_write_data, 32'h11);
        chk("b2b_mem_second", 100, mem_alu_result, 32'h22);
        chk("b2b_fwd_newest", 100, 32'(forward_a), 32'(2'b10));
        @(negedge clk);
        #2;
        chk("b2b_wb_second", 101, wb_write_data, 32'h22);
        chk("b2b_wb_addr", 101, 32'(wb_write_addr), 32'd6);
        chk("b2b_wb_we", 101, 32'(wb_reg_write), 32'd1);

        // Reset with two writes in flight: nothing may be written back afterwards.
        @(negedge clk);
        drive(0, 0, 1, 0, 5'd10, 32'hA0, 5'd0, 5'd0, 32'h0);
        @(negedge clk);
        drive(0, 0, 1, 1, 5'd11, 32'hB0, 5'd0, 5'd0, 32'h0);
        @(negedge clk);
        drive(1, 0, 1, 0, 5'd12, 32'hC0, 5'd0, 5'd0, 32'hFF);
        @(negedge clk);
        drive(0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk("post_reset_wb_we", 200 + c, 32'(wb_reg_write), 32'd0);
            chk("post_reset_mem_we", 200 + c, 32'(mem_reg_write), 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
